// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Contents:
//   tx_state_e   - transmitter FSM states
//   PAR_*        - parity_type encodings
//   calc_parity  - parity bit over the low n bits of a data word
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } tx_state_e;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam int unsigned PAR_DATA_W = 16;

  // Parity over data[n-1:0] only; bits at or above n never contribute.
  function automatic logic calc_parity(input logic [PAR_DATA_W-1:0] data,
                                       input logic [3:0]            n,
                                       input logic [1:0]            ptype);
    logic x;
    logic par;
    x = 1'b0;
    for (int i = 0; i < PAR_DATA_W; i++) begin
      x = x ^ (data[i] & (i < int'(n)));
    end
    case (ptype)
      PAR_EVEN:  par = x;
      PAR_ODD:   par = ~x;
      PAR_MARK:  par = 1'b1;
      PAR_SPACE: par = 1'b0;
      default:   par = x;
    endcase
    return par;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with count-based full/empty and show-ahead read data.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   push_i/push_data_i - write request and data (ignored when full)
//   pop_i             - read request (ignored when empty)
//   pop_data_o        - word at the head of the FIFO
//   full_o, empty_o   - occupancy flags
//   count_o           - words held
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok_s  = push_i & ~full_o;
  assign pop_ok_s   = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // storage write
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: TX FIFO, programmable baud divider, 5..MAX_DATA_W data
// bits, even/odd/mark/space parity, 1 or 2 stop bits, CTS flow control and
// break generation.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   baud_div            - bit period = baud_div+1 cycles
//   data_bit_num        - data bits (clamped to 5..MAX_DATA_W)
//   stop_bit_num        - 0: one stop bit, 1: two
//   parity_en/parity_type - parity enable and mode
//   cts_n               - peer clear-to-send (async, active-low)
//   send_break          - hold line low while set (between frames)
//   wr_valid/wr_data/wr_ready - FIFO write port
//   tx                  - serial output
//   busy                - FSM not idle
//   tx_done             - one-cycle pulse per completed frame
//   fifo_count          - words held in the FIFO
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int MAX_DATA_W = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [3:0]                    data_bit_num,
  input  logic                          stop_bit_num,
  input  logic                          parity_en,
  input  logic [1:0]                    parity_type,
  input  logic                          cts_n,
  input  logic                          send_break,
  input  logic                          wr_valid,
  input  logic [MAX_DATA_W-1:0]         wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [3:0] MAX_N = 4'(MAX_DATA_W);
  localparam logic [3:0] MIN_N = 4'd5;

  tx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic [3:0]            nbits_q, nbits_d;
  logic                  stop2_q, stop2_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic [MAX_DATA_W-1:0] data_q, data_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  brk_rel_q, brk_rel_d;
  logic                  cts_s1_q, cts_s2_q;

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [MAX_DATA_W-1:0] fifo_rd_data_s;
  logic                  launch_s;
  logic                  start_ok_s;
  logic [3:0]            nbits_eff_s;

  uart_sync_fifo #(
    .WIDTH (MAX_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (wr_valid),
    .push_data_i (wr_data),
    .pop_i       (launch_s),
    .pop_data_o  (fifo_rd_data_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count)
  );

  assign wr_ready   = ~fifo_full_s;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign start_ok_s = ~fifo_empty_s & ~cts_s2_q & ~send_break;

  // clamp requested data width into the supported range
  always_comb begin
    nbits_eff_s = data_bit_num;
    if (data_bit_num < MIN_N) begin
      nbits_eff_s = MIN_N;
    end else if (data_bit_num > MAX_N) begin
      nbits_eff_s = MAX_N;
    end else begin
      nbits_eff_s = data_bit_num;
    end
  end

  // next-state, bit sequencing and line value
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    nbits_d   = nbits_q;
    stop2_d   = stop2_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    data_d    = data_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    brk_rel_d = brk_rel_q;
    launch_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (start_ok_s) begin
          launch_s = 1'b1;
        end else if (send_break) begin
          state_d   = ST_BREAK;
          tx_d      = 1'b0;
          brk_rel_d = 1'b0;
          div_d     = baud_div;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          bit_d   = 4'd0;
          tx_d    = data_q[0];
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_q;
          if (bit_q == (nbits_q - 4'd1)) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
              bit_d   = 4'd0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = data_q[bit_q + 4'd1];
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      ST_PARITY: begin
        if (cnt_q == '0) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          bit_d   = 4'd0;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == '0) begin
          if (stop2_q && (bit_q == 4'd0)) begin
            bit_d = 4'd1;
            cnt_d = div_q;
          end else begin
            done_d = 1'b1;
            // chain straight into the next frame when allowed
            if (start_ok_s) begin
              launch_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      ST_BREAK: begin
        if (!brk_rel_q) begin
          tx_d = 1'b0;
          // on release, hold mark for one full bit period before leaving
          if (!send_break) begin
            brk_rel_d = 1'b1;
            tx_d      = 1'b1;
            cnt_d     = div_q;
          end else begin
            brk_rel_d = 1'b0;
          end
        end else begin
          tx_d = 1'b1;
          if (cnt_q == '0) begin
            state_d   = ST_IDLE;
            brk_rel_d = 1'b0;
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // frame launch: pop the head word and freeze the line configuration
    if (launch_s) begin
      state_d   = ST_START;
      tx_d      = 1'b0;
      cnt_d     = baud_div;
      div_d     = baud_div;
      bit_d     = 4'd0;
      nbits_d   = nbits_eff_s;
      stop2_d   = stop_bit_num;
      par_en_d  = parity_en;
      par_bit_d = calc_parity(PAR_DATA_W'(fifo_rd_data_s), nbits_eff_s, parity_type);
      data_d    = fifo_rd_data_s;
    end else begin
      data_d = data_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= 4'd0;
      nbits_q   <= MIN_N;
      stop2_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      brk_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      nbits_q   <= nbits_d;
      stop2_q   <= stop2_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      brk_rel_q <= brk_rel_d;
    end
  end

  // two-flop CTS synchroniser; resets to "not clear"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= cts_n;
      cts_s2_q <= cts_s1_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed stimulus, frame scoreboard
// and a line monitor that decodes tx and compares against expected frames.
module tb_uart_tx_core;

  logic        clk;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [3:0]  data_bit_num;
  logic        stop_bit_num;
  logic        parity_en;
  logic [1:0]  parity_type;
  logic        cts_n;
  logic        send_break;
  logic        wr_valid;
  logic [8:0]  wr_data;
  logic        wr_ready;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic [4:0]  fifo_count;

  uart_tx_core #(
    .MAX_DATA_W (9),
    .FIFO_DEPTH (16),
    .DIV_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_div     (baud_div),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .cts_n        (cts_n),
    .send_break   (send_break),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;   // LSB = start bit
    int          len;    // total bits in frame
    int          per;    // cycles per bit
  } frame_t;

  frame_t sb[$];
  int     n_cmp  = 0;
  int     n_fail = 0;
  int     done_cnt = 0;
  int     gap_cnt = 0;
  bit     gap_en = 1'b0;
  bit     ignore_low = 1'b0;
  bit     mon_active = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected frame from the current line configuration
  function automatic frame_t make_frame(input logic [8:0] d);
    frame_t f;
    int     n;
    int     idx;
    logic   x;
    logic   p;
    n = int'(data_bit_num);
    if (n < 5) n = 5;
    if (n > 9) n = 9;
    f.bits = '0;
    f.bits[0] = 1'b0;
    idx = 1;
    x = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[idx] = d[i];
      x = x ^ d[i];
      idx++;
    end
    if (parity_en) begin
      case (parity_type)
        2'b00:   p = x;
        2'b01:   p = ~x;
        2'b10:   p = 1'b1;
        default: p = 1'b0;
      endcase
      f.bits[idx] = p;
      idx++;
    end
    f.bits[idx] = 1'b1;
    idx++;
    if (stop_bit_num) begin
      f.bits[idx] = 1'b1;
      idx++;
    end
    f.len = idx;
    f.per = int'(baud_div) + 1;
    return f;
  endfunction

  // line monitor: decode each frame, check bits and the tx_done pulse
  initial begin
    frame_t      cur;
    int          cyc;
    logic [15:0] rec;
    cyc = 0;
    rec = '0;
    cur.bits = '0;
    cur.len = 1;
    cur.per = 1;
    forever begin
      @(negedge clk);
      if (tx_done) done_cnt++;
      if (gap_en && !busy && fifo_count != 5'd0) gap_cnt++;
      if (!rst_n) begin
        mon_active = 1'b0;
      end else begin
        if (mon_active && cyc == cur.len * cur.per) begin
          check("tx_done_at_frame_end", {31'd0, tx_done}, 32'd1);
          check("frame_bits", {16'd0, rec}, {16'd0, cur.bits});
          mon_active = 1'b0;
        end
        if (!mon_active && tx == 1'b0 && !ignore_low) begin
          check("start_has_expected_frame", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            mon_active = 1'b1;
            cyc = 0;
            rec = '0;
          end
        end
        if (mon_active) begin
          if ((cyc % cur.per) == (cur.per / 2) && (cyc / cur.per) < 16)
            rec[cyc / cur.per] = tx;
          cyc++;
        end
      end
    end
  end

  task automatic write_word(input logic [8:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = d;
    if (wr_ready) sb.push_back(make_frame(d));
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || fifo_count != 5'd0 || sb.size() != 0 || mon_active) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_within_budget", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic set_cfg(input int div, input int nb, input logic s2,
                         input logic pe, input logic [1:0] pt);
    baud_div     = 16'(div);
    data_bit_num = 4'(nb);
    stop_bit_num = s2;
    parity_en    = pe;
    parity_type  = pt;
  endtask

  initial begin
    int d0;
    int mark;
    int n;
    rst_n = 1'b0;
    cts_n = 1'b0;
    send_break = 1'b0;
    wr_valid = 1'b0;
    wr_data = 9'd0;
    set_cfg(3, 8, 1'b0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 8N1, baud_div=3, 0xA5, with start-latency check
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 9'h0A5;
    check("wr_ready_empty", {31'd0, wr_ready}, 32'd1);
    sb.push_back(make_frame(9'h0A5));
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check("lat_tx_high_after_push", {31'd0, tx}, 32'd1);
    check("lat_count_after_push", {27'd0, fifo_count}, 32'd1);
    @(posedge clk);
    #1;
    check("lat_tx_fall", {31'd0, tx}, 32'd0);
    check("lat_busy", {31'd0, busy}, 32'd1);
    check("lat_count_after_pop", {27'd0, fifo_count}, 32'd0);
    wait_idle(200);

    // 7 bits, 2 stop, odd / mark / space parity
    set_cfg(1, 7, 1'b1, 1'b1, 2'b01);
    write_word(9'h083);
    wait_idle(200);
    set_cfg(1, 7, 1'b1, 1'b1, 2'b10);
    write_word(9'h083);
    wait_idle(200);
    set_cfg(1, 7, 1'b1, 1'b1, 2'b11);
    write_word(9'h083);
    wait_idle(200);

    // 9 bits even parity; 3 requested bits behaves as 5
    set_cfg(1, 9, 1'b0, 1'b1, 2'b00);
    write_word(9'h1FF);
    wait_idle(200);
    set_cfg(1, 3, 1'b0, 1'b0, 2'b00);
    write_word(9'h1F5);
    wait_idle(200);
    set_cfg(0, 12, 1'b0, 1'b1, 2'b01);
    write_word(9'h155);
    wait_idle(200);

    // CTS held off: fill FIFO, 17th write rejected, then burst
    set_cfg(0, 8, 1'b0, 1'b0, 2'b00);
    cts_n = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 17; i++) write_word(9'(i * 7 + 3));
    #1;
    check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("full_count", {27'd0, fifo_count}, 32'd16);
    check("full_sb_size", sb.size(), 32'd16);
    repeat (20) @(posedge clk);
    #1;
    check("cts_hold_tx", {31'd0, tx}, 32'd1);
    check("cts_hold_busy", {31'd0, busy}, 32'd0);
    d0 = done_cnt;
    cts_n = 1'b0;
    n = 0;
    while (!busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("burst_started", {31'd0, busy}, 32'd1);
    gap_cnt = 0;
    gap_en = 1'b1;
    wait_idle(400);
    gap_en = 1'b0;
    check("burst_no_gap", gap_cnt, 32'd0);
    check("burst_done_pulses", done_cnt - d0, 32'd16);

    // CTS raised mid-frame: frame finishes, next one waits
    set_cfg(3, 8, 1'b0, 1'b0, 2'b00);
    write_word(9'h03C);
    write_word(9'h0C3);
    repeat (8) @(posedge clk);
    cts_n = 1'b1;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("cts_frame_completed", {31'd0, done_cnt != d0}, 32'd1);
    repeat (60) @(posedge clk);
    #1;
    check("cts_wait_tx", {31'd0, tx}, 32'd1);
    check("cts_wait_busy", {31'd0, busy}, 32'd0);
    check("cts_wait_count", {27'd0, fifo_count}, 32'd1);
    cts_n = 1'b0;
    wait_idle(200);

    // break requested mid-frame
    write_word(9'h0F0);
    repeat (6) @(posedge clk);
    ignore_low = 1'b1;
    send_break = 1'b1;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("brk_frame_completed", {31'd0, done_cnt != d0}, 32'd1);
    n = 0;
    while (tx && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("brk_line_low", {31'd0, tx}, 32'd0);
    check("brk_busy", {31'd0, busy}, 32'd1);
    write_word(9'h05A);
    repeat (20) @(posedge clk);
    #1;
    check("brk_hold_low", {31'd0, tx}, 32'd0);
    check("brk_word_waits", {27'd0, fifo_count}, 32'd1);
    @(negedge clk);
    send_break = 1'b0;
    @(posedge clk);
    #1;
    ignore_low = 1'b0;
    mark = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tx) break;
      mark++;
    end
    check("brk_mark_after_release", {31'd0, mark >= 4}, 32'd1);
    wait_idle(200);

    // reset in the middle of DATA
    write_word(9'h0AA);
    write_word(9'h011);
    write_word(9'h022);
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_count", {27'd0, fifo_count}, 32'd0);
    check("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    write_word(9'h0E7);
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Parametrised UART transmitter with an internal transmit FIFO, programmable baud divider, 5..MAX_DATA_W data bits, four parity modes, 1/2 stop bits, CTS flow control and break generation. It replaces the fixed 8-bit, single-word transmit path as the TX half of the UART. It feeds the line driver `tx` from a valid/ready write port.

## Interface
- `MAX_DATA_W`, 9, widest supported data field (5..9)
- `FIFO_DEPTH`, 16, TX FIFO words; power of two, ≥2
- `DIV_W`, 16, baud divider width
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `baud_div`  in  DIV_W  bit period = baud_div+1 clk cycles
- `data_bit_num`  in  4  data bits; <5 treated as 5, >MAX_DATA_W treated as MAX_DATA_W
- `stop_bit_num`  in  1  0 = 1 stop bit, 1 = 2 stop bits
- `parity_en`  in  1  1 = parity bit present
- `parity_type`  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
- `cts_n`  in  1  peer clear-to-send, active-low, asynchronous; 2-FF synchronised internally
- `send_break`  in  1  level request to hold line low
- `wr_valid`  in  1  write request
- `wr_data`  in  MAX_DATA_W  word to send, LSB first
- `wr_ready`  out  1  = FIFO not full; reset 1
- `tx`  out  1  serial line; reset 1
- `busy`  out  1  state ≠ IDLE; reset 0
- `tx_done`  out  1  one-cycle pulse per completed frame; reset 0
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words held; reset 0

## Operation
- Push on `wr_valid && wr_ready`. `wr_ready` depends only on count, so there is no push when full, even with a same-cycle pop.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE → START when FIFO is non-empty, synced `cts_n`=0 and `send_break`=0. The word is popped on that edge. `baud_div`, `data_bit_num`, `stop_bit_num`, `parity_en` and `parity_type` are latched on the same edge and held for the whole frame.
- START: `tx`=0 for one bit period. DATA then sends n bits LSB first; bits above n are ignored.
- PARITY is entered only when `parity_en`=1. Its value is computed over the n sent bits only: even/odd by XOR, mark = 1, space = 0.
- STOP: `tx`=1 for 1 or 2 bit periods.
- `tx_done` pulses in the cycle after the final stop period ends.
- At stop end, if start conditions hold, go directly to START (no idle cycle). Otherwise go to IDLE.
- CTS is checked only at frame start. Deassertion mid-frame does not abort the frame.
- BREAK: entered from IDLE when `send_break`=1, with `tx`=0 while held. A break request during a frame is deferred to the frame end. On release, `tx`=1 for at least one full bit period before the next START.
- Reset at any time: `tx`=1, FIFO empty, IDLE, bit/baud counters cleared, all outputs at reset values immediately.

## Timing
- Start latency: `tx` falls on the edge after the word becomes visible in an empty FIFO, plus 2 cycles of CTS sync latency if `cts_n` just fell.
- Frame length = (1 + n + p + s) × (baud_div+1) cycles; `baud_div`=0 is legal (1-cycle bits).
- Baud counter counts down from the latched divider; the bit advances on reaching 0.
- `fifo_count` updates on the push/pop edge. A simultaneous push and pop leaves it unchanged.

## Structure
- Package `uart_pkg`:
  - `tx_state_e` enum
  - `parity_type` constants
  - function `calc_parity(data, n, type)`
- Sub-module `uart_sync_fifo` (WIDTH, DEPTH):
  - single clock, async reset
  - count-based full/empty
  - pointers wrap at DEPTH
- The FSM, baud counter and CTS synchroniser live in `uart_tx_core`.

## Test plan
- baud_div=3, 8N1, write 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; `tx_done` 40 cycles after the falling edge.
- data_bit_num=7, odd parity, 2 stop, write 0x83 → data 1,1,0,0,0,0,0 (bit 7 ignored), parity 1, two stop bits; repeat with mark and space → parity 1, then 0.
- data_bit_num=9, even parity, write 0x1FF → nine 1s then parity 1; data_bit_num=3 → behaves as 5 bits.
- `cts_n`=1, write 17 words with FIFO_DEPTH=16 → `wr_ready`=0 after 16, `fifo_count`=16, `tx` stays 1. Drop `cts_n` → 16 back-to-back frames with no idle gap and 16 `tx_done` pulses.
- Raise `cts_n` mid-frame → the frame completes and the next frame waits. Assert `send_break` mid-frame → break starts after stop, and ≥1 bit of mark follows release.
- Assert `rst_n`=0 mid-DATA → `tx`=1, `busy`=0, `fifo_count`=0, `wr_ready`=1 the same cycle; normal operation after release.
